// File: rtl/x2050cy_pkg.sv
// x2050cy_pkg: DG/AD field codes, AD decode and stack-operation encoding
// shared by the x2050cyx carry latch file and its save stack.
package x2050cy_pkg;

   // DG field: adder carry-in selection
   localparam logic [2:0] DG_CARRY = 3'd1;
   localparam logic [2:0] DG_ONE_A = 3'd2;
   localparam logic [2:0] DG_ONE_B = 3'd4;

   // AD field: carry latch set sources
   localparam logic [3:0] AD_C0   = 4'd4;
   localparam logic [3:0] AD_C0X1 = 4'd5;
   localparam logic [3:0] AD_C1   = 4'd6;
   localparam logic [3:0] AD_C8   = 4'd7;

   // Result of decoding AD: set=1 means the selected latch takes val
   typedef struct packed {
      logic set;
      logic val;
   } ad_dec_t;

   // Stack request, encoded directly as {push, pop}
   typedef enum logic [1:0] {
      STK_IDLE = 2'b00,
      STK_POP  = 2'b01,
      STK_PUSH = 2'b10,
      STK_SWAP = 2'b11
   } stk_op_e;

   function automatic ad_dec_t ad_decode(input logic [3:0] ad,
                                         input logic c0,
                                         input logic c1,
                                         input logic c8);
      ad_dec_t d;
      d.set = 1'b1;
      d.val = 1'b0;
      case (ad)
         AD_C0:   d.val = c0;
         AD_C0X1: d.val = c0 ^ c1;
         AD_C1:   d.val = c1;
         AD_C8:   d.val = c8;
         default: d.set = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/x2050cyx_if.sv
// x2050cyx_if: control inputs and carry/stack outputs of the x2050cyx
// carry latch file. The design side uses the slave modport.
//
// Handshake: there is no ready path. i_ros_advance, i_push and i_pop are
// single-cycle strobes; each one asserted at a rising edge is acted on at
// that edge and never stalls or back-pressures.
interface x2050cyx_if #(
   parameter int NCH   = 2,
   parameter int DEPTH = 4
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW  = $clog2(DEPTH + 1);

   logic           i_ros_advance;
   logic           i_io_mode;
   logic [CHW-1:0] i_chan;
   logic [2:0]     i_dg;
   logic [3:0]     i_ad;
   logic           i_c0;
   logic           i_c1;
   logic           i_c8;
   logic           i_push;
   logic           i_pop;

   logic           o_carry_in;
   logic           o_next_carry;
   logic [NCH-1:0] o_carry;
   logic [DW-1:0]  o_depth;
   logic           o_full;
   logic           o_empty;
   logic           o_ovf;
   logic           o_unf;

   modport master (
      output i_ros_advance, i_io_mode, i_chan, i_dg, i_ad,
             i_c0, i_c1, i_c8, i_push, i_pop,
      input  o_carry_in, o_next_carry, o_carry, o_depth,
             o_full, o_empty, o_ovf, o_unf
   );

   modport slave (
      input  i_ros_advance, i_io_mode, i_chan, i_dg, i_ad,
             i_c0, i_c1, i_c8, i_push, i_pop,
      output o_carry_in, o_next_carry, o_carry, o_depth,
             o_full, o_empty, o_ovf, o_unf
   );

endinterface

// File: rtl/x2050cy_stack.sv
// x2050cy_stack: NCH-wide, DEPTH-deep LIFO of carry-vector snapshots with
// push, pop and swap (push+pop), occupancy and sticky overflow/underflow.
// o_restore/o_data tell the owner to reload its carry vector this edge.
module x2050cy_stack
   import x2050cy_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int DEPTH = 4,
   localparam int DW   = $clog2(DEPTH + 1)
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   input  logic           i_push,
   input  logic           i_pop,
   input  logic [NCH-1:0] i_data,
   output logic           o_restore,
   output logic [NCH-1:0] o_data,
   output logic [DW-1:0]  o_depth,
   output logic           o_full,
   output logic           o_empty,
   output logic           o_ovf,
   output logic           o_unf
);

   logic [NCH-1:0] mem_q [DEPTH];
   logic [NCH-1:0] mem_d [DEPTH];
   logic [DW-1:0]  depth_q, depth_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic           full, empty;
   logic [NCH-1:0] top_entry;
   stk_op_e        op;

   assign full  = (depth_q == DW'(DEPTH));
   assign empty = (depth_q == '0);
   assign op    = stk_op_e'({i_push, i_pop});

   // Read the entry just below the stack pointer (the most recent snapshot)
   always_comb begin
      top_entry = '0;
      for (int i = 0; i < DEPTH; i++)
         if (DW'(i + 1) == depth_q) top_entry = mem_q[i];
   end

   // Next stack contents, occupancy and flags for the requested operation
   always_comb begin
      mem_d     = mem_q;
      depth_d   = depth_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      o_restore = 1'b0;
      case (op)
         STK_PUSH: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++)
                  if (DW'(i) == depth_q) mem_d[i] = i_data;
               depth_d = depth_q + DW'(1);
            end
         end
         STK_POP: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               o_restore = 1'b1;
               depth_d   = depth_q - DW'(1);
            end
         end
         STK_SWAP: begin
            if (empty) begin
               // Nothing to swap with: behaves as a plain push into slot 0
               mem_d[0] = i_data;
               depth_d  = DW'(1);
               unf_d    = 1'b1;
            end else begin
               o_restore = 1'b1;
               for (int i = 0; i < DEPTH; i++)
                  if (DW'(i + 1) == depth_q) mem_d[i] = i_data;
            end
         end
         default: ;
      endcase
   end

   // Occupancy and sticky flags; cleared only by reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Snapshot storage; contents above the pointer are don't-care
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   assign o_data  = top_entry;
   assign o_depth = depth_q;
   assign o_full  = full;
   assign o_empty = empty;
   assign o_ovf   = ovf_q;
   assign o_unf   = unf_q;

endmodule

// File: rtl/x2050cyx.sv
// x2050cyx: per-channel carry latch file for the 2050 datapath. Decodes
// adder carry-in from DG, updates the selected channel's latch from AD on
// each ROS advance, and (with X2050CYX_STACK_EN defined) saves/restores the
// whole carry vector across micro-interrupts via x2050cy_stack.
module x2050cyx
   import x2050cy_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int DEPTH = 4
) (
   input logic         i_clk,
   input logic         i_reset_n,
   x2050cyx_if.slave   bus
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW  = $clog2(DEPTH + 1);

   logic [NCH-1:0] carry_q, carry_d;
   logic [CHW-1:0] ch_idx;
   logic           sel;
   logic           cin;
   ad_dec_t        dec;
   logic           restore;
   logic [NCH-1:0] restore_data;
   logic [DW-1:0]  depth;
   logic           full, empty, ovf, unf;

   // Channel numbers beyond the implemented set fall back to channel 0
   always_comb begin
      ch_idx = (int'(bus.i_chan) < NCH) ? bus.i_chan : '0;
   end

   // Current latch of the selected channel
   always_comb begin
      sel = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (CHW'(i) == ch_idx) sel = carry_q[i];
   end

   assign dec = ad_decode(bus.i_ad, bus.i_c0, bus.i_c1, bus.i_c8);

   // Adder carry-in from DG; I/O mode forces it low
   always_comb begin
      case (bus.i_dg)
         DG_CARRY:           cin = sel;
         DG_ONE_A, DG_ONE_B: cin = 1'b1;
         default:            cin = 1'b0;
      endcase
   end

   // Next carry vector: AD update on advance, overridden by a stack restore
   always_comb begin
      carry_d = carry_q;
      if (bus.i_ros_advance && dec.set) begin
         for (int i = 0; i < NCH; i++)
            if (CHW'(i) == ch_idx) carry_d[i] = dec.val;
      end
      if (restore) carry_d = restore_data;
   end

   // Carry latches
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) carry_q <= '0;
      else            carry_q <= carry_d;
   end

`ifdef X2050CYX_STACK_EN
   x2050cy_stack #(
      .NCH   (NCH),
      .DEPTH (DEPTH)
   ) u_stack (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (bus.i_push),
      .i_pop     (bus.i_pop),
      .i_data    (carry_q),
      .o_restore (restore),
      .o_data    (restore_data),
      .o_depth   (depth),
      .o_full    (full),
      .o_empty   (empty),
      .o_ovf     (ovf),
      .o_unf     (unf)
   );
`else
   // No save stack: push/pop have no effect and status stays idle
   logic unused_stack_req;
   assign unused_stack_req = &{1'b0, bus.i_push, bus.i_pop};
   assign restore      = 1'b0;
   assign restore_data = '0;
   assign depth        = '0;
   assign full         = 1'b0;
   assign empty        = 1'b1;
   assign ovf          = 1'b0;
   assign unf          = 1'b0;
`endif

   assign bus.o_carry_in   = cin & ~bus.i_io_mode;
   assign bus.o_next_carry = dec.set ? dec.val : sel;
   assign bus.o_carry      = carry_q;
   assign bus.o_depth      = depth;
   assign bus.o_full       = full;
   assign bus.o_empty      = empty;
   assign bus.o_ovf        = ovf;
   assign bus.o_unf        = unf;

endmodule

// File: tb/tb_x2050cyx.sv
// tb_x2050cyx: self-checking bench for x2050cyx (NCH=2, DEPTH=4). Works
// with or without X2050CYX_STACK_EN; stack scenarios follow the macro.
module tb_x2050cyx;

   localparam int NCH   = 2;
   localparam int DEPTH = 4;
   localparam int CHW   = 1;
   localparam int DW    = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   // Reference model: carry vector, snapshot stack (back = top), flags
   logic [NCH-1:0] m_carry = '0;
   logic [NCH-1:0] exp_q[$];
   logic           m_ovf = 1'b0;
   logic           m_unf = 1'b0;

   x2050cyx_if #(.NCH(NCH), .DEPTH(DEPTH)) bus ();

   x2050cyx #(.NCH(NCH), .DEPTH(DEPTH)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic logic m_sel();
      int ch;
      ch = (int'(bus.i_chan) < NCH) ? int'(bus.i_chan) : 0;
      return m_carry[ch];
   endfunction

   // {set, value} of the AD field
   function automatic logic [1:0] m_ad();
      case (bus.i_ad)
         4'd4:    return {1'b1, bus.i_c0};
         4'd5:    return {1'b1, bus.i_c0 ^ bus.i_c1};
         4'd6:    return {1'b1, bus.i_c1};
         4'd7:    return {1'b1, bus.i_c8};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic m_cin();
      if (bus.i_io_mode) return 1'b0;
      if (bus.i_dg == 3'd1) return m_sel();
      if (bus.i_dg == 3'd2 || bus.i_dg == 3'd4) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_next();
      logic [1:0] a;
      a = m_ad();
      return a[1] ? a[0] : m_sel();
   endfunction

   function automatic logic [8:0] m_status();
      return {m_carry, DW'(exp_q.size()), exp_q.size() == DEPTH,
              exp_q.size() == 0, m_ovf, m_unf};
   endfunction

   function automatic logic [8:0] dut_status();
      return {bus.o_carry, bus.o_depth, bus.o_full, bus.o_empty,
              bus.o_ovf, bus.o_unf};
   endfunction

   // Apply one clock edge to the model using the inputs present at the edge
   task automatic model_edge();
      logic [NCH-1:0] pre;
      logic [NCH-1:0] nxt;
      logic [1:0]     a;
      int             ch;
      if (!rst_n) begin
         m_carry = '0;
         exp_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         pre = m_carry;
         nxt = m_carry;
         a   = m_ad();
         ch  = (int'(bus.i_chan) < NCH) ? int'(bus.i_chan) : 0;
         if (bus.i_ros_advance && a[1]) nxt[ch] = a[0];
`ifdef X2050CYX_STACK_EN
         if (bus.i_push && bus.i_pop) begin
            if (exp_q.size() == 0) begin
               exp_q.push_back(pre);
               m_unf = 1'b1;
            end else begin
               nxt = exp_q.pop_back();
               exp_q.push_back(pre);
            end
         end else if (bus.i_push) begin
            if (exp_q.size() == DEPTH) m_ovf = 1'b1;
            else exp_q.push_back(pre);
         end else if (bus.i_pop) begin
            if (exp_q.size() == 0) m_unf = 1'b1;
            else nxt = exp_q.pop_back();
         end
`endif
         m_carry = nxt;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      bus.i_ros_advance = 1'b0;
      bus.i_io_mode     = 1'b0;
      bus.i_chan        = '0;
      bus.i_dg          = 3'd0;
      bus.i_ad          = 4'd0;
      bus.i_c0          = 1'b0;
      bus.i_c1          = 1'b0;
      bus.i_c8          = 1'b0;
      bus.i_push        = 1'b0;
      bus.i_pop         = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_chan(input int ch, input logic [3:0] ad, input logic v);
      idle();
      bus.i_ros_advance = 1'b1;
      bus.i_chan = CHW'(ch);
      bus.i_ad = ad;
      bus.i_c1 = v;
      bus.i_c8 = v;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      bus.i_push = 1'b1;
      bus.i_ros_advance = 1'b1;
      bus.i_ad = 4'd7;
      bus.i_c8 = 1'b1;
      cycle();
      cycle();
      total++;
      if (dut_status() !== 9'b00_000_0_1_0_0) begin
         bad++;
         $display("FAIL reset_state got=%b exp=%b", dut_status(), 9'b00_000_0_1_0_0);
      end
      rst_n = 1'b1;
      idle();
      cycle();
   endtask

   task automatic test_decode();
      idle();
      bus.i_chan = 1'b1;
      bus.i_ad = 4'd5;
      bus.i_c0 = 1'b1;
      bus.i_c1 = 1'b0;
      bus.i_ros_advance = 1'b1;
      #1;
      total++;
      if (bus.o_next_carry !== 1'b1) begin
         bad++;
         $display("FAIL decode_next got=%b exp=1", bus.o_next_carry);
      end
      cycle();
      total++;
      if (bus.o_carry !== 2'b10) begin
         bad++;
         $display("FAIL decode_carry got=%b exp=10", bus.o_carry);
      end
      idle();
      bus.i_chan = 1'b1;
      bus.i_dg = 3'd1;
      #1;
      total++;
      if (bus.o_carry_in !== 1'b1) begin
         bad++;
         $display("FAIL cin_dg1 got=%b exp=1", bus.o_carry_in);
      end
      bus.i_io_mode = 1'b1;
      #1;
      total++;
      if (bus.o_carry_in !== 1'b0) begin
         bad++;
         $display("FAIL cin_iomode got=%b exp=0", bus.o_carry_in);
      end
      bus.i_io_mode = 1'b0;
      bus.i_dg = 3'd4;
      #1;
      total++;
      if (bus.o_carry_in !== 1'b1) begin
         bad++;
         $display("FAIL cin_dg4 got=%b exp=1", bus.o_carry_in);
      end
      bus.i_dg = 3'd3;
      #1;
      total++;
      if (bus.o_carry_in !== 1'b0) begin
         bad++;
         $display("FAIL cin_dg3 got=%b exp=0", bus.o_carry_in);
      end
      bus.i_dg = 3'd1;
      bus.i_chan = 1'b0;
      #1;
      total++;
      if (bus.o_carry_in !== 1'b0) begin
         bad++;
         $display("FAIL cin_dg1_ch0 got=%b exp=0", bus.o_carry_in);
      end
   endtask

   task automatic test_hold();
      // carry is 2'b10 here
      idle();
      bus.i_chan = 1'b1;
      bus.i_ad = 4'd3;
      bus.i_ros_advance = 1'b1;
      bus.i_c0 = 1'b0;
      bus.i_c1 = 1'b0;
      bus.i_c8 = 1'b0;
      #1;
      total++;
      if (bus.o_next_carry !== 1'b1) begin
         bad++;
         $display("FAIL hold_next_ad3 got=%b exp=1", bus.o_next_carry);
      end
      cycle();
      total++;
      if (bus.o_carry !== 2'b10) begin
         bad++;
         $display("FAIL hold_carry_ad3 got=%b exp=10", bus.o_carry);
      end
      idle();
      bus.i_ad = 4'd7;
      bus.i_c8 = 1'b1;
      #1;
      total++;
      if (bus.o_next_carry !== 1'b1) begin
         bad++;
         $display("FAIL hold_next_noadv got=%b exp=1", bus.o_next_carry);
      end
      cycle();
      total++;
      if (bus.o_carry !== 2'b10) begin
         bad++;
         $display("FAIL hold_carry_noadv got=%b exp=10", bus.o_carry);
      end
   endtask

`ifdef X2050CYX_STACK_EN
   task automatic test_stack();
      set_chan(0, 4'd7, 1'b1); cycle();
      set_chan(1, 4'd6, 1'b0); cycle();
      total++;
      if (bus.o_carry !== 2'b01) begin
         bad++;
         $display("FAIL stack_setup got=%b exp=01", bus.o_carry);
      end
      idle(); bus.i_push = 1'b1; cycle();
      total++;
      if (dut_status() !== 9'b01_001_0_0_0_0) begin
         bad++;
         $display("FAIL stack_push got=%b exp=%b", dut_status(), 9'b01_001_0_0_0_0);
      end
      set_chan(0, 4'd7, 1'b0); cycle();
      set_chan(1, 4'd6, 1'b1); cycle();
      idle(); bus.i_pop = 1'b1; cycle();
      total++;
      if (dut_status() !== 9'b01_000_0_1_0_0) begin
         bad++;
         $display("FAIL stack_pop got=%b exp=%b", dut_status(), 9'b01_000_0_1_0_0);
      end
      cycle();
      total++;
      if (dut_status() !== 9'b01_000_0_1_0_1) begin
         bad++;
         $display("FAIL stack_underflow got=%b exp=%b", dut_status(), 9'b01_000_0_1_0_1);
      end
   endtask

   task automatic test_full();
      int             chs  [5] = '{0, 1, 0, 1, 0};
      logic [3:0]     ads  [5] = '{4'd7, 4'd6, 4'd7, 4'd6, 4'd7};
      logic           vals [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [NCH-1:0] pops [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      rst_n = 1'b0; idle(); cycle(); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_chan(chs[i], ads[i], vals[i]);
         bus.i_push = 1'b1;
         cycle();
      end
      total++;
      if (dut_status() !== 9'b01_100_1_0_1_0) begin
         bad++;
         $display("FAIL full_state got=%b exp=%b", dut_status(), 9'b01_100_1_0_1_0);
      end
      idle();
      bus.i_pop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         total++;
         if (bus.o_carry !== pops[i] || bus.o_depth !== DW'(3 - i)) begin
            bad++;
            $display("FAIL full_pop%0d got carry=%b depth=%0d exp carry=%b depth=%0d",
                     i, bus.o_carry, bus.o_depth, pops[i], 3 - i);
         end
      end
      idle();
   endtask

   task automatic test_swap();
      rst_n = 1'b0; idle(); cycle(); rst_n = 1'b1;
      idle(); bus.i_push = 1'b1; cycle();
      set_chan(0, 4'd7, 1'b1); cycle();
      set_chan(1, 4'd6, 1'b1); cycle();
      set_chan(0, 4'd7, 1'b0);
      bus.i_push = 1'b1;
      bus.i_pop = 1'b1;
      cycle();
      total++;
      if (dut_status() !== 9'b00_001_0_0_0_0) begin
         bad++;
         $display("FAIL swap_state got=%b exp=%b", dut_status(), 9'b00_001_0_0_0_0);
      end
      idle(); bus.i_pop = 1'b1; cycle();
      total++;
      if (dut_status() !== 9'b11_000_0_1_0_0) begin
         bad++;
         $display("FAIL swap_top got=%b exp=%b", dut_status(), 9'b11_000_0_1_0_0);
      end
      idle(); bus.i_push = 1'b1; bus.i_pop = 1'b1; cycle();
      total++;
      if (dut_status() !== 9'b11_001_0_0_0_1) begin
         bad++;
         $display("FAIL swap_empty got=%b exp=%b", dut_status(), 9'b11_001_0_0_0_1);
      end
      idle();
   endtask
`else
   task automatic test_nostack();
      for (int i = 0; i < 6; i++) begin
         idle();
         bus.i_push = (i % 3) != 1;
         bus.i_pop  = (i % 3) != 0;
         cycle();
      end
      total++;
      if (dut_status() !== {m_carry, 7'b000_0_1_0_0}) begin
         bad++;
         $display("FAIL nostack_status got=%b exp=%b", dut_status(), {m_carry, 7'b000_0_1_0_0});
      end
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         bus.i_ros_advance = 1'($urandom_range(0, 1));
         bus.i_io_mode     = ($urandom_range(0, 3) == 0);
         bus.i_chan        = CHW'($urandom_range(0, NCH - 1));
         bus.i_dg          = 3'($urandom_range(0, 7));
         bus.i_ad          = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(4, 7))
                                                         : 4'($urandom_range(0, 15));
         bus.i_c0          = 1'($urandom_range(0, 1));
         bus.i_c1          = 1'($urandom_range(0, 1));
         bus.i_c8          = 1'($urandom_range(0, 1));
         bus.i_push        = ($urandom_range(0, 2) == 0);
         bus.i_pop         = ($urandom_range(0, 2) == 0);
         #1;
         total++;
         if (bus.o_carry_in !== m_cin()) begin
            bad++;
            $display("FAIL rand_cin n=%0d got=%b exp=%b", n, bus.o_carry_in, m_cin());
         end
         total++;
         if (bus.o_next_carry !== m_next()) begin
            bad++;
            $display("FAIL rand_next n=%0d got=%b exp=%b", n, bus.o_next_carry, m_next());
         end
         cycle();
         total++;
         if (dut_status() !== m_status()) begin
            bad++;
            $display("FAIL rand_status n=%0d got=%b exp=%b", n, dut_status(), m_status());
         end
      end
      rst_n = 1'b1;
      idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle();
      test_reset();
      test_decode();
      test_hold();
`ifdef X2050CYX_STACK_EN
      test_stack();
      test_full();
      test_swap();
`else
      test_nostack();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
